// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost flags,
// overflow/underflow pulses and optional first-word-fall-through read.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   w_en, data_in     write request and write data
//   r_en, data_out    read request and read data
//   full, empty       count == DEPTH, count == 0
//   almost_full       count >= AF_LEVEL
//   almost_empty      count <= AE_LEVEL
//   count             occupancy, 0..DEPTH
//   overflow          one-cycle pulse after a rejected write
//   underflow         one-cycle pulse after a rejected read
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   w_en,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   r_en,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  logic wr_acc;
  logic rd_acc;

  // Flags decode the registered count so they never lag it.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  always_comb begin
    wr_acc   = w_en && !full;
    rd_acc   = r_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    ovf_d    = w_en && full;
    unf_d    = r_en && empty;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q];
    end

    if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is not reset; writes in the reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // FWFT presents the head word directly; the output register is
  // then unused and trimmed by synthesis.
  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = mem_q[rd_ptr_q];
    end else begin : g_std
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock FIFO, next generation of the team's synchronous FIFO. Adds configurable width/depth, occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode. Sits between a producer and consumer in the same clock domain and drops into the existing FIFO interface/bench with the extra ports left unconnected or checked.

## Interface
Parameters:
- DATA_WIDTH, 8: word width in bits (>=1)
- DEPTH, 16: number of entries; power of two, >=2
- AF_LEVEL, DEPTH-2: almost_full asserted when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2: almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
- FWFT, 0: 0 = standard registered read, 1 = first-word-fall-through

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- w_en  in  1  write request
- data_in  in  DATA_WIDTH  write data, sampled with w_en
- r_en  in  1  read request
- data_out  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Storage: DEPTH x DATA_WIDTH array; wr_ptr/rd_ptr are $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally.
- Write accepted iff w_en && !full (full as registered at that edge): mem[wr_ptr] <= data_in, wr_ptr++.
- Read accepted iff r_en && !empty: rd_ptr++.
- Simultaneous accepted read+write: count unchanged. When full, only the read is accepted; when empty, only the write is accepted (no bypass of data_in to data_out).
- count: +1 write-only, -1 read-only, unchanged otherwise. All flags are combinational decodes of registered count (no extra lag vs count).
- overflow <= w_en && full; underflow <= r_en && empty; registered, high for exactly one cycle per rejected request. Rejected request has no other effect.
- FWFT=0: data_out register loads mem[rd_ptr] on an accepted read, holds otherwise.
- FWFT=1: data_out = mem[rd_ptr] continuously; valid whenever !empty; value while empty unspecified and not checked. r_en acknowledges/pops the presented word.
- Reset (rst_n low at a clock edge): pointers, count 0; empty=1, almost_empty=1 (AE_LEVEL>=0), full=0, almost_full=0, overflow=0, underflow=0, data_out=0 (FWFT=0). Memory contents not cleared. Requests in the reset cycle ignored. Reset mid-operation discards all stored words.

## Timing
- Write at edge N: count/empty/flags update after edge N; read accepted earliest at edge N+1.
- FWFT=0: read accepted at edge N -> data_out valid after edge N (one-cycle latency), held until next accepted read.
- FWFT=1: word written at edge N (into empty FIFO) visible on data_out after edge N; read at edge N+1 advances to next word after N+1.
- full asserts after the edge accepting the DEPTH-th write; deasserts after the edge of the first accepted read.
- overflow/underflow assert after the offending edge, clear after the following edge unless repeated.
- Sustained throughput: one write and one read per cycle, indefinitely, at any 0<count<DEPTH.

## Test plan
- Reset: hold rst_n=0 two cycles with w_en=r_en=1 -> count=0, empty=1, almost_empty=1, full=0, overflow=underflow=0, data_out=0.
- Fill (DEPTH=16, AF=14): write 0x01..0x10 back-to-back -> almost_full rises after 14th write, full after 16th, count=16; 17th write 0xAA -> overflow pulse one cycle, count stays 16, 0xAA never read.
- Drain: read 16 times -> data_out 0x01..0x10 in order, each one cycle after its r_en (FWFT=0); empty after 16th; extra read -> underflow pulse, data_out holds 0x10.
- Simultaneous: at count=5 assert w_en&&r_en 20 cycles with incrementing data -> count stays 5, output order preserved across pointer wrap; at count=16 both -> read accepted, overflow=1, count=15; at count=0 both -> underflow=1, count=1.
- FWFT=1: write 0x5A into empty FIFO -> data_out=0x5A and empty=0 the next cycle with no r_en; r_en one cycle -> empty=1.
- Mid-operation reset at count=9 -> next cycle count=0, empty=1; subsequent write 0x33 then read returns 0x33.
